// File: rtl/vx_dot8_accum.sv
// vx_dot8_accum: per-warp, per-lane accumulator for the packed-int8 dot8 ALU
// result stream. Packets from in_first to in_last are summed per lane, and
// the final sums are emitted through a one-entry valid/ready output register.
// Optional feature: define VX_DOT8_ACC_SAT_EN for signed-saturating lane sums
// (default build wraps in 32-bit two's complement).
module vx_dot8_accum #(
    parameter int unsigned NUM_LANES = 1,
    parameter int unsigned NUM_WARPS = 4,
    parameter int unsigned TAG_WIDTH = 8,
    localparam int unsigned NW_BITS = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NW_BITS-1:0]      in_wid,
    input  logic [NUM_LANES-1:0]    in_tmask,
    input  logic                    in_first,
    input  logic                    in_last,
    input  logic [NUM_LANES*32-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]    in_tag,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [NW_BITS-1:0]      out_wid,
    output logic [NUM_LANES-1:0]    out_tmask,
    output logic [NUM_LANES*32-1:0] out_data,
    output logic [TAG_WIDTH-1:0]    out_tag,
    output logic                    busy
);

    logic [31:0]             acc_q [NUM_WARPS][NUM_LANES];
    logic [NUM_WARPS-1:0]    open_q;
    logic [31:0]             base  [NUM_LANES];
    logic [NUM_LANES*32-1:0] nxt_lanes;
    logic                    accept;
    logic                    cont;

    // Per-lane add; saturates on signed overflow when the feature is enabled.
    function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b);
`ifdef VX_DOT8_ACC_SAT_EN
        logic [31:0] s;
        s = a + b;
        if ((a[31] == b[31]) && (s[31] != a[31]))
            lane_add = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else
            lane_add = s;
`else
        lane_add = a + b;
`endif
    endfunction

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign busy     = |open_q;

    // New per-lane accumulator values for the addressed warp. An inactive lane
    // keeps its base, which is already zero whenever the warp restarts.
    always_comb begin
        cont      = open_q[in_wid] && !in_first;
        nxt_lanes = '0;
        for (int unsigned i = 0; i < NUM_LANES; i++) begin
            base[i] = cont ? acc_q[in_wid][i] : '0;
            nxt_lanes[32*i +: 32] = in_tmask[i] ? lane_add(base[i], in_data[32*i +: 32])
                                                : base[i];
        end
    end

    // Accumulator and open-flag update on every accepted packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned w = 0; w < NUM_WARPS; w++)
                for (int unsigned i = 0; i < NUM_LANES; i++)
                    acc_q[w][i] <= '0;
            open_q <= '0;
        end else if (accept) begin
            for (int unsigned i = 0; i < NUM_LANES; i++)
                acc_q[in_wid][i] <= nxt_lanes[32*i +: 32];
            open_q[in_wid] <= !in_last;
        end
    end

    // One-entry output register: loads on an accepted last packet, clears on drain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_wid   <= '0;
            out_tmask <= '0;
            out_data  <= '0;
            out_tag   <= '0;
        end else if (accept && in_last) begin
            out_valid <= 1'b1;
            out_wid   <= in_wid;
            out_tmask <= in_tmask;
            out_data  <= nxt_lanes;
            out_tag   <= in_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vx_dot8_accum.sv
// Self-checking bench for vx_dot8_accum (2 lanes, 4 warps). A scoreboard model
// computes expected sums from plain arithmetic; directed literals pin the model.
module tb_vx_dot8_accum;

    localparam int NL  = 2;
    localparam int NW  = 4;
    localparam int TW  = 8;
    localparam int NWB = 2;

    logic            clk, reset_n;
    logic            in_valid, in_ready, in_first, in_last;
    logic [NWB-1:0]  in_wid, out_wid;
    logic [NL-1:0]   in_tmask, out_tmask;
    logic [NL*32-1:0] in_data, out_data;
    logic [TW-1:0]   in_tag, out_tag;
    logic            out_valid, out_ready, busy;

    vx_dot8_accum #(.NUM_LANES(NL), .NUM_WARPS(NW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_wid(in_wid),
        .in_tmask(in_tmask), .in_first(in_first), .in_last(in_last),
        .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_wid(out_wid),
        .out_tmask(out_tmask), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    typedef struct packed {
        logic [NWB-1:0]   wid;
        logic [NL-1:0]    tmask;
        logic [NL*32-1:0] data;
        logic [TW-1:0]    tag;
    } rec_t;

    rec_t        q[$];
    rec_t        hist[$];
    logic [31:0] m_acc [NW][NL];
    bit          m_open [NW];
    int          total = 0;
    int          bad = 0;
    bit          rdy_rand = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] m_add(input logic [31:0] a, input logic [31:0] b);
        longint     s;
        logic [63:0] t;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef VX_DOT8_ACC_SAT_EN
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
        t = s;
        return t[31:0];
    endfunction

    function automatic bit m_busy();
        bit b = 0;
        for (int w = 0; w < NW; w++) b |= m_open[w];
        return b;
    endfunction

    task automatic m_reset();
        q.delete();
        for (int w = 0; w < NW; w++) begin
            m_open[w] = 0;
            for (int i = 0; i < NL; i++) m_acc[w][i] = '0;
        end
    endtask

    task automatic m_apply(input int w, input logic [NL-1:0] tm, input bit f, input bit l,
                           input logic [NL*32-1:0] d, input logic [TW-1:0] tg);
        rec_t        r;
        logic [31:0] b, nv;
        r.wid = w[NWB-1:0]; r.tmask = tm; r.tag = tg; r.data = '0;
        for (int i = 0; i < NL; i++) begin
            b  = (m_open[w] && !f) ? m_acc[w][i] : 32'd0;
            nv = tm[i] ? m_add(b, d[32*i +: 32]) : b;
            m_acc[w][i] = nv;
            r.data[32*i +: 32] = nv;
        end
        m_open[w] = !l;
        if (l) begin
            q.push_back(r);
            hist.push_back(r);
        end
    endtask

    // Compare process: checks outputs against the model, then advances the model.
    always @(negedge clk) begin
        bit ev, acc;
        if (!reset_n) begin
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_tag", out_tag, 0);
            chk("rst_out_tmask", out_tmask, 0);
            chk("rst_out_wid", out_wid, 0);
            chk("rst_busy", busy, 0);
            m_reset();
        end else begin
            ev = (q.size() != 0);
            chk("out_valid", out_valid, ev);
            chk("in_ready", in_ready, !ev || out_ready);
            chk("busy", busy, m_busy());
            if (ev) begin
                chk("out_wid", out_wid, q[0].wid);
                chk("out_tmask", out_tmask, q[0].tmask);
                chk("out_data", out_data, q[0].data);
                chk("out_tag", out_tag, q[0].tag);
            end
            acc = in_valid && (!ev || out_ready);
            if (ev && out_ready) void'(q.pop_front());
            if (acc) m_apply(int'(in_wid), in_tmask, in_first, in_last, in_data, in_tag);
        end
    end

    always @(posedge clk) begin
        #2;
        if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Drive one packet (entered and left 2 time units after a rising edge).
    task automatic send(input int w, input logic [NL-1:0] tm, input bit f, input bit l,
                        input logic [NL*32-1:0] d, input logic [TW-1:0] tg);
        int n = 0;
        in_valid = 1; in_wid = w[NWB-1:0]; in_tmask = tm; in_first = f;
        in_last = l; in_data = d; in_tag = tg;
        #1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #3; n++;
        end
        if (n >= 200) chk("send_timeout", 1, 0);
        @(posedge clk); #2;
        in_valid = 0;
        in_tmask = NL'($urandom); in_tag = TW'($urandom);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); n++;
        end
        if (n >= 200) chk("drain_timeout", 1, 0);
        @(posedge clk); #2;
    endtask

    initial begin
        int h;
        logic [31:0] e0, e1;
        reset_n = 0; in_valid = 0; in_wid = '0; in_tmask = '0; in_first = 0;
        in_last = 0; in_data = '0; in_tag = '0; out_ready = 1;
        m_reset();
        repeat (3) @(posedge clk);
        #2 reset_n = 1;

        // Accumulation on warp 0: 10 - 3 + 100 = 107 (lane 1: 1 + 2 + 3 = 6)
        h = hist.size();
        send(0, 2'b11, 1, 0, {32'd1, 32'd10}, 8'h11);
        send(0, 2'b11, 0, 0, {32'd2, 32'hFFFF_FFFD}, 8'h12);
        send(0, 2'b11, 0, 1, {32'd3, 32'd100}, 8'hA5);
        wait_idle();
        chk("acc_count", hist.size() - h, 1);
        chk("acc_data", hist[h].data, {32'd6, 32'd107});
        chk("acc_wid", hist[h].wid, 0);

        // Single-packet pass-through, only lane 0 active
        h = hist.size();
        send(2, 2'b01, 1, 1, {32'd9, 32'd7}, 8'h3C);
        wait_idle();
        chk("single_data", hist[h].data, {32'd0, 32'd7});
        chk("single_tmask", hist[h].tmask, 2'b01);

        // Interleaved warps
        h = hist.size();
        send(0, 2'b01, 1, 0, {32'd0, 32'd1}, 8'h00);
        send(1, 2'b01, 1, 0, {32'd0, 32'd1000}, 8'h00);
        send(0, 2'b01, 0, 1, {32'd0, 32'd2}, 8'h20);
        send(1, 2'b01, 0, 1, {32'd0, 32'hFFFF_FFFF}, 8'h21);
        wait_idle();
        chk("ilv_w0", {hist[h].wid, hist[h].data[31:0]}, {2'd0, 32'd3});
        chk("ilv_w1", {hist[h+1].wid, hist[h+1].data[31:0]}, {2'd1, 32'd999});

        // Backpressure: held output for 3 cycles, then drain and accept together
        h = hist.size();
        send(2, 2'b01, 1, 0, {32'd0, 32'd40}, 8'h00);
        out_ready = 0;
        send(3, 2'b01, 1, 1, {32'd0, 32'd7}, 8'h33);
        fork
            send(2, 2'b01, 0, 1, {32'd0, 32'd2}, 8'h42);
            begin repeat (3) @(posedge clk); #2 out_ready = 1; end
        join
        wait_idle();
        chk("bp_first", hist[h].data[31:0], 32'd7);
        chk("bp_second", hist[h+1].data[31:0], 32'd42);

        // Overflow on both lanes
`ifdef VX_DOT8_ACC_SAT_EN
        e0 = 32'h7FFF_FFFF; e1 = 32'h8000_0000;
`else
        e0 = 32'h8000_0010; e1 = 32'h7FFF_FFFF;
`endif
        h = hist.size();
        send(1, 2'b11, 1, 0, {32'h8000_0000, 32'h7FFF_FFF0}, 8'h00);
        send(1, 2'b11, 0, 1, {32'hFFFF_FFFF, 32'h0000_0020}, 8'h77);
        wait_idle();
        chk("ovf_pos", hist[h].data[31:0], e0);
        chk("ovf_neg", hist[h].data[63:32], e1);

        // Reset mid-sequence: warp 1 open and an output pending
        send(1, 2'b11, 1, 0, {32'd4, 32'd3}, 8'h00);
        out_ready = 0;
        send(0, 2'b11, 1, 1, {32'd8, 32'd8}, 8'h99);
        reset_n = 0;
        @(posedge clk); #2;
        reset_n = 1; out_ready = 1;
        h = hist.size();
        send(1, 2'b01, 0, 1, {32'd99, 32'd5}, 8'h55);
        wait_idle();
        chk("post_rst", hist[h].data, {32'd0, 32'd5});

        // Randomized traffic with random backpressure
        rdy_rand = 1;
        for (int k = 0; k < 400; k++) begin
            logic [NL*32-1:0] d;
            for (int i = 0; i < NL; i++) begin
                case ($urandom_range(0, 3))
                    0: d[32*i +: 32] = 32'($urandom_range(0, 200)) - 32'd100;
                    1: d[32*i +: 32] = 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                    2: d[32*i +: 32] = 32'h8000_0000 + 32'($urandom_range(0, 255));
                    default: d[32*i +: 32] = $urandom;
                endcase
            end
            send(int'($urandom_range(0, NW - 1)), NL'($urandom), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), d, TW'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #2;
            end
        end
        rdy_rand = 0;
        #1 out_ready = 1;
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
